// File: rtl/rvc_expander.sv
// RV32C-to-RV32I expander: turns a compressed halfword into its 32-bit base-ISA
// encoding and passes full-length instructions through. Purely combinational.
module rvc_expander (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [31:0] instr_out
);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [4:0] X0 = 5'd0;
  localparam logic [4:0] RA = 5'd1;
  localparam logic [4:0] SP = 5'd2;

  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [31:0] ILLEGAL = 32'h0000_0000;

  // Clock and reset exist only for interface uniformity.
  logic unused_ok;
  assign unused_ok = ^{clk, rst};

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;

  assign c    = instr[15:0];
  assign rd   = c[11:7];
  assign rs2  = c[6:2];
  assign rdp  = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};

  // Immediates already unscrambled into their natural bit positions.
  logic [11:0] imm6;
  logic [11:0] addi4spn_imm;
  logic [11:0] lw_imm;
  logic [11:0] addi16sp_imm;
  logic [11:0] lwsp_imm;
  logic [11:0] swsp_imm;
  logic [19:0] lui_imm;
  logic [20:0] j_imm;
  logic [12:0] b_imm;

  assign imm6         = {{6{c[12]}}, c[12], c[6:2]};
  assign addi4spn_imm = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign lw_imm       = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign addi16sp_imm = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0};
  assign lwsp_imm     = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign swsp_imm     = {4'b0, c[8:7], c[12:9], 2'b00};
  assign lui_imm      = {{14{c[12]}}, c[12], c[6:2]};
  assign j_imm        = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11],
                         c[5:3], 1'b0};
  assign b_imm        = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};

  logic [2:0] alu_f3;
  logic [6:0] alu_f7;

  always_comb begin
    alu_f3 = 3'b000;
    alu_f7 = 7'b0000000;
    case (c[6:5])
      2'b00:   begin alu_f3 = 3'b000; alu_f7 = 7'b0100000; end
      2'b01:   alu_f3 = 3'b100;
      2'b10:   alu_f3 = 3'b110;
      default: alu_f3 = 3'b111;
    endcase
  end

  always_comb begin
    instr_out = ILLEGAL;
    if (instr[1:0] == 2'b11) begin
      instr_out = instr;
    end else begin
      case ({c[1:0], c[15:13]})
        // Quadrant 0; a zero nzuimm also covers the all-zero halfword.
        5'b00_000: if (addi4spn_imm != 12'd0)
                     instr_out = {addi4spn_imm, SP, 3'b000, rdp, OP_IMM};
        5'b00_010: instr_out = {lw_imm, rs1p, 3'b010, rdp, OP_LOAD};
        5'b00_110: instr_out = {lw_imm[11:5], rdp, rs1p, 3'b010, lw_imm[4:0], OP_STORE};
        // Quadrant 1
        5'b01_000: instr_out = {imm6, rd, 3'b000, rd, OP_IMM};
        5'b01_001: instr_out = {j_imm[20], j_imm[10:1], j_imm[11], j_imm[19:12], RA, OP_JAL};
        5'b01_010: instr_out = {imm6, X0, 3'b000, rd, OP_IMM};
        5'b01_011: begin
          if (rd == SP) instr_out = {addi16sp_imm, SP, 3'b000, SP, OP_IMM};
          else          instr_out = {lui_imm, rd, OP_LUI};
        end
        5'b01_100: begin
          case (c[11:10])
            2'b00: instr_out = {7'b0000000, rs2, rs1p, 3'b101, rs1p, OP_IMM};
            2'b01: instr_out = {7'b0100000, rs2, rs1p, 3'b101, rs1p, OP_IMM};
            2'b10: instr_out = {imm6, rs1p, 3'b111, rs1p, OP_IMM};
            default: if (!c[12])
                       instr_out = {alu_f7, rdp, rs1p, alu_f3, rs1p, OP_REG};
          endcase
        end
        5'b01_101: instr_out = {j_imm[20], j_imm[10:1], j_imm[11], j_imm[19:12], X0, OP_JAL};
        5'b01_110: instr_out = {b_imm[12], b_imm[10:5], X0, rs1p, 3'b000, b_imm[4:1],
                                b_imm[11], OP_BRANCH};
        5'b01_111: instr_out = {b_imm[12], b_imm[10:5], X0, rs1p, 3'b001, b_imm[4:1],
                                b_imm[11], OP_BRANCH};
        // Quadrant 2
        5'b10_000: instr_out = {7'b0000000, rs2, rd, 3'b001, rd, OP_IMM};
        5'b10_010: instr_out = {lwsp_imm, SP, 3'b010, rd, OP_LOAD};
        5'b10_100: begin
          if (!c[12]) begin
            if (rs2 == X0) instr_out = {12'd0, rd, 3'b000, X0, OP_JALR};
            else           instr_out = {7'b0000000, rs2, X0, 3'b000, rd, OP_REG};
          end else begin
            if (rd == X0 && rs2 == X0) instr_out = EBREAK;
            else if (rs2 == X0)        instr_out = {12'd0, rd, 3'b000, RA, OP_JALR};
            else                       instr_out = {7'b0000000, rs2, rd, 3'b000, rd, OP_REG};
          end
        end
        5'b10_110: instr_out = {swsp_imm[11:5], rs2, SP, 3'b010, swsp_imm[4:0], OP_STORE};
        default:   instr_out = ILLEGAL;
      endcase
    end
  end

endmodule

// File: tb/tb_rvc_expander.sv
// Bench for rvc_expander: directed vectors plus random halfwords compared against
// an arithmetic reference model of the compressed-ISA expansion rules.
module tb_rvc_expander;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic [31:0] instr_out;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  rvc_expander dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .instr_out (instr_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: instr=%h got=%h expected=%h", tag, instr, got, exp);
    end
  endtask

  function automatic int fld(input int v, input int hi, input int lo);
    return (v >> lo) & ((1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic int sext(input int v, input int n);
    return fld(v, n - 1, n - 1) != 0 ? v - (1 << n) : v;
  endfunction

  function automatic int enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return ((imm & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
  endfunction

  function automatic int enc_s(input int imm, input int rs2, input int rs1, input int f3);
    return (fld(imm, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
           (fld(imm, 4, 0) << 7) | 'h23;
  endfunction

  function automatic int enc_b(input int imm, input int rs1, input int f3);
    return (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (rs1 << 15) | (f3 << 12) |
           (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | 'h63;
  endfunction

  function automatic int enc_j(input int imm, input int rd);
    return (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20) |
           (fld(imm, 19, 12) << 12) | (rd << 7) | 'h6f;
  endfunction

  function automatic int enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
  endfunction

  // Reference: immediates are built as integer sums of weighted bits, then encoded.
  function automatic logic [31:0] model(input logic [31:0] w);
    int c, q, f3, rd, rs2, rdp, rs1p, imm6, shamt, off, r;
    if (w[1:0] == 2'b11) return w;
    c     = int'({16'h0, w[15:0]});
    q     = fld(c, 1, 0);
    f3    = fld(c, 15, 13);
    rd    = fld(c, 11, 7);
    rs2   = fld(c, 6, 2);
    shamt = rs2;
    rdp   = 8 + fld(c, 4, 2);
    rs1p  = 8 + fld(c, 9, 7);
    imm6  = sext(fld(c, 12, 12) * 32 + fld(c, 6, 2), 6);
    r     = 0;
    if (q == 0) begin
      off = fld(c, 12, 10) * 8 + fld(c, 6, 6) * 4 + fld(c, 5, 5) * 64;
      case (f3)
        0: begin
          off = fld(c, 12, 11) * 16 + fld(c, 10, 7) * 64 + fld(c, 6, 6) * 4 + fld(c, 5, 5) * 8;
          if (off != 0) r = enc_i(off, 2, 0, rdp, 'h13);
        end
        2: r = enc_i(off, rs1p, 2, rdp, 'h03);
        6: r = enc_s(off, rdp, rs1p, 2);
        default: r = 0;
      endcase
    end else if (q == 1) begin
      case (f3)
        0: r = enc_i(imm6, rd, 0, rd, 'h13);
        1, 5: begin
          off = sext(fld(c, 12, 12) * 2048 + fld(c, 11, 11) * 16 + fld(c, 10, 9) * 256 +
                     fld(c, 8, 8) * 1024 + fld(c, 7, 7) * 64 + fld(c, 6, 6) * 128 +
                     fld(c, 5, 3) * 2 + fld(c, 2, 2) * 32, 12);
          r = enc_j(off, f3 == 1 ? 1 : 0);
        end
        2: r = enc_i(imm6, 0, 0, rd, 'h13);
        3: begin
          if (rd == 2) begin
            off = sext(fld(c, 12, 12) * 512 + fld(c, 6, 6) * 16 + fld(c, 5, 5) * 64 +
                       fld(c, 4, 3) * 128 + fld(c, 2, 2) * 32, 10);
            r = enc_i(off, 2, 0, 2, 'h13);
          end else begin
            r = ((imm6 & 'hfffff) << 12) | (rd << 7) | 'h37;
          end
        end
        4: begin
          case (fld(c, 11, 10))
            0: r = enc_i(shamt, rs1p, 5, rs1p, 'h13);
            1: r = enc_i(shamt + 'h400, rs1p, 5, rs1p, 'h13);
            2: r = enc_i(imm6, rs1p, 7, rs1p, 'h13);
            default: begin
              if (fld(c, 12, 12) == 0)
                case (fld(c, 6, 5))
                  0: r = enc_r(32, rdp, rs1p, 0, rs1p);
                  1: r = enc_r(0, rdp, rs1p, 4, rs1p);
                  2: r = enc_r(0, rdp, rs1p, 6, rs1p);
                  default: r = enc_r(0, rdp, rs1p, 7, rs1p);
                endcase
            end
          endcase
        end
        default: begin
          off = sext(fld(c, 12, 12) * 256 + fld(c, 11, 10) * 8 + fld(c, 6, 5) * 64 +
                     fld(c, 4, 3) * 2 + fld(c, 2, 2) * 32, 9);
          r = enc_b(off, rs1p, f3 == 6 ? 0 : 1);
        end
      endcase
    end else begin
      case (f3)
        0: r = enc_i(shamt, rd, 1, rd, 'h13);
        2: r = enc_i(fld(c, 12, 12) * 32 + fld(c, 6, 4) * 4 + fld(c, 3, 2) * 64, 2, 2, rd, 'h03);
        6: r = enc_s(fld(c, 12, 9) * 4 + fld(c, 8, 7) * 64, rs2, 2, 2);
        4: begin
          if (fld(c, 12, 12) == 0)
            r = (rs2 == 0) ? enc_i(0, rd, 0, 0, 'h67) : enc_r(0, rs2, 0, 0, rd);
          else if (rd == 0 && rs2 == 0)
            r = 'h00100073;
          else
            r = (rs2 == 0) ? enc_i(0, rd, 0, 1, 'h67) : enc_r(0, rs2, rd, 0, rd);
        end
        default: r = 0;
      endcase
    end
    return 32'(r);
  endfunction

  logic [31:0] vin  [10] = '{32'h0005A503, 32'hFFFF4515, 32'h00001141, 32'h00004188,
                             32'h0000852E, 32'h00008082, 32'h00009002, 32'h00000000,
                             32'hFFFFFFFF, 32'hABCD0000};
  logic [31:0] vexp [10] = '{32'h0005A503, 32'h00500513, 32'hFF010113, 32'h0005A503,
                             32'h00B00533, 32'h00008067, 32'h00100073, 32'h00000000,
                             32'hFFFFFFFF, 32'h00000000};

  initial begin
    logic [31:0] w;
    // Held in reset with an all-zero window.
    @(negedge clk);
    check("reset", instr_out, 32'h0);
    @(posedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      instr = vin[i];
      @(negedge clk);
      check("directed", instr_out, vexp[i]);
    end

    // Reset asserted mid-stream must not disturb the expansion.
    @(posedge clk);
    instr = 32'hFFFF4515;
    rst   = 1'b1;
    @(negedge clk);
    check("rst_mid", instr_out, 32'h00500513);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold", instr_out, 32'h00500513);
    rst = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      w = $urandom;
      if ($urandom_range(3) != 0) w[1:0] = 2'($urandom_range(2));
      instr = w;
      rst   = ($urandom_range(15) == 0);
      @(negedge clk);
      check("random", instr_out, model(w));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
